// File: rtl/sha_msg_padder_pkg.sv
// Shared constants and state type for the SHA-256 message padder.
package sha_pkg;

  localparam int         BLOCK_WIDTH      = 512;
  localparam int         LEN_FIELD_WIDTH  = 64;
  localparam logic [7:0] PAD_BYTE         = 8'h80;
  localparam int         BLOCK_BYTES      = BLOCK_WIDTH / 8;
  localparam int         LEN_FIELD_OFFSET = BLOCK_BYTES - LEN_FIELD_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    PAD,
    EMIT,
    DONE
  } padState_e;

endpackage

// File: rtl/sha_msg_padder_if.sv
// Signal bundle between the padder, its message SRAM and the block consumer.
interface sha_msg_padder_if #(
  parameter int SYMBOL_WIDTH = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int LEN_WIDTH    = 11
);
  import sha_pkg::*;

  logic                    go_sig;
  logic [LEN_WIDTH-1:0]    msg_len;
  logic                    msg_mem_en;
  logic [ADDR_WIDTH-1:0]   msg_mem_addr;
  logic [SYMBOL_WIDTH-1:0] msg_mem_data;
  logic [BLOCK_WIDTH-1:0]  blk_data;
  logic                    blk_valid;
  logic                    blk_ready;
  logic                    blk_last;
  logic                    busy;
  logic                    pad_msg_rdy;

  modport master (
    input  go_sig, msg_len, msg_mem_data, blk_ready,
    output msg_mem_en, msg_mem_addr, blk_data, blk_valid, blk_last, busy, pad_msg_rdy
  );

  modport slave (
    output go_sig, msg_len, msg_mem_data, blk_ready,
    input  msg_mem_en, msg_mem_addr, blk_data, blk_valid, blk_last, busy, pad_msg_rdy
  );

endinterface

// File: rtl/sha_msg_padder_assembler.sv
// 64-byte block register: byte-lane writes of SRAM words, pad byte and length insertion.
module sha_block_assembler
  import sha_pkg::*;
#(
  parameter int SYMBOL_WIDTH = 8,
  parameter int CNT_WIDTH    = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       clear_i,
  input  logic                       wrEn_i,
  input  logic [5:0]                 wrOff_i,
  input  logic [CNT_WIDTH-1:0]       wrCnt_i,
  input  logic [SYMBOL_WIDTH-1:0]    wrData_i,
  input  logic                       padEn_i,
  input  logic [5:0]                 padOff_i,
  input  logic                       lenEn_i,
  input  logic [LEN_FIELD_WIDTH-1:0] lenBits_i,
  output logic [BLOCK_WIDTH-1:0]     block_o
);

  localparam int BPW = SYMBOL_WIDTH / 8;

  // Index 0 is the most significant byte, so the packed vector is already in wire order.
  logic [0:BLOCK_BYTES-1][7:0] block_q, block_d;
  logic [5:0]                  lane;

  always_comb begin
    block_d = block_q;
    lane    = '0;
    if (clear_i) begin
      block_d = '0;
    end else begin
      if (wrEn_i) begin
        for (int k = 0; k < BPW; k++) begin
          lane = wrOff_i + 6'(k);
          if (k < int'(wrCnt_i)) block_d[lane] = wrData_i[SYMBOL_WIDTH-1-8*k -: 8];
        end
      end
      if (padEn_i) block_d[padOff_i] = PAD_BYTE;
      if (lenEn_i) block_d[LEN_FIELD_OFFSET:BLOCK_BYTES-1] = lenBits_i;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) block_q <= '0;
    else          block_q <= block_d;
  end

  assign block_o = block_q;

endmodule

// File: rtl/sha_msg_padder.sv
// Multi-block SHA-256 padder: streams a message from SRAM and emits padded 512-bit blocks.
module sha_msg_padder
  import sha_pkg::*;
#(
  parameter int MAX_MESSAGE_LENGTH = 1024,
  parameter int SYMBOL_WIDTH       = 8,
  parameter int ADDR_WIDTH         = $clog2((MAX_MESSAGE_LENGTH*8+SYMBOL_WIDTH-1)/SYMBOL_WIDTH)
) (
  input logic              clock,
  input logic              reset_n,
  sha_msg_padder_if.master bus
);

  localparam int LEN_WIDTH = $clog2(MAX_MESSAGE_LENGTH + 1);
  localparam int BPW       = SYMBOL_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(BPW + 1);

  padState_e              state_q, state_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d, left_q, left_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [6:0]             blkOff_q, blkOff_d;
  logic                   fetchDone_q, fetchDone_d;
  logic                   padPlaced_q, padPlaced_d;
  logic                   last_q, last_d;
  logic                   rdValid_q;
  logic [5:0]             rdOff_q;
  logic [CNT_WIDTH-1:0]   rdCnt_q;
  logic                   issue, clear, padEn, lenEn;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [BLOCK_WIDTH-1:0] block;

  assign cnt = (left_q < LEN_WIDTH'(BPW)) ? CNT_WIDTH'(left_q) : CNT_WIDTH'(BPW);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    left_d      = left_q;
    addr_d      = addr_q;
    blkOff_d    = blkOff_q;
    fetchDone_d = fetchDone_q;
    padPlaced_d = padPlaced_q;
    last_d      = last_q;
    issue       = 1'b0;
    clear       = 1'b0;
    padEn       = 1'b0;
    lenEn       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.go_sig) begin
          len_d       = bus.msg_len;
          left_d      = bus.msg_len;
          addr_d      = '0;
          blkOff_d    = '0;
          fetchDone_d = 1'b0;
          padPlaced_d = 1'b0;
          last_d      = 1'b0;
          clear       = 1'b1;
          state_d     = (bus.msg_len == '0) ? PAD : FETCH;
        end
      end
      FETCH: begin
        // Once every read for this block is out, spend one cycle collecting the last word.
        if (fetchDone_q) begin
          state_d = PAD;
        end else begin
          issue    = 1'b1;
          addr_d   = addr_q + 1'b1;
          blkOff_d = blkOff_q + 7'(cnt);
          left_d   = left_q - LEN_WIDTH'(cnt);
          if (blkOff_d == 7'd64 || left_d == '0) fetchDone_d = 1'b1;
        end
      end
      PAD: begin
        state_d = EMIT;
        if (blkOff_q == 7'd64) begin
          last_d = 1'b0;
        end else if (padPlaced_q) begin
          lenEn  = 1'b1;
          last_d = 1'b1;
        end else begin
          padEn       = 1'b1;
          padPlaced_d = 1'b1;
          if (blkOff_q <= 7'd55) begin
            lenEn  = 1'b1;
            last_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (bus.blk_ready) begin
          if (last_q) begin
            state_d = DONE;
          end else begin
            clear       = 1'b1;
            blkOff_d    = '0;
            fetchDone_d = 1'b0;
            state_d     = (left_q != '0) ? FETCH : PAD;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      left_q      <= '0;
      addr_q      <= '0;
      blkOff_q    <= '0;
      fetchDone_q <= 1'b0;
      padPlaced_q <= 1'b0;
      last_q      <= 1'b0;
      rdValid_q   <= 1'b0;
      rdOff_q     <= '0;
      rdCnt_q     <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      left_q      <= left_d;
      addr_q      <= addr_d;
      blkOff_q    <= blkOff_d;
      fetchDone_q <= fetchDone_d;
      padPlaced_q <= padPlaced_d;
      last_q      <= last_d;
      rdValid_q   <= issue;
      rdOff_q     <= blkOff_q[5:0];
      rdCnt_q     <= cnt;
    end
  end

  sha_block_assembler #(
    .SYMBOL_WIDTH (SYMBOL_WIDTH),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_assembler (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear_i   (clear),
    .wrEn_i    (rdValid_q),
    .wrOff_i   (rdOff_q),
    .wrCnt_i   (rdCnt_q),
    .wrData_i  (bus.msg_mem_data),
    .padEn_i   (padEn),
    .padOff_i  (blkOff_q[5:0]),
    .lenEn_i   (lenEn),
    .lenBits_i (LEN_FIELD_WIDTH'(len_q) << 3),
    .block_o   (block)
  );

  assign bus.msg_mem_en   = issue;
  assign bus.msg_mem_addr = addr_q;
  assign bus.blk_data     = block;
  assign bus.blk_valid    = (state_q == EMIT);
  assign bus.blk_last     = (state_q == EMIT) && last_q;
  assign bus.busy         = (state_q == FETCH) || (state_q == PAD) || (state_q == EMIT);
  assign bus.pad_msg_rdy  = (state_q == DONE);

endmodule

// File: tb/tb_sha_msg_padder.sv
// Directed bench for sha_msg_padder with an 8-bit and a 32-bit SRAM instance.
module tb_sha_msg_padder;
  import sha_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  int         numChecks;
  int         numFails;
  logic [7:0]  msgBytes [1024];
  logic [31:0] mem32 [256];

  always #5 clock = ~clock;

  sha_msg_padder_if #(.SYMBOL_WIDTH(8),  .ADDR_WIDTH(10), .LEN_WIDTH(11)) bus8 ();
  sha_msg_padder_if #(.SYMBOL_WIDTH(32), .ADDR_WIDTH(8),  .LEN_WIDTH(11)) bus32 ();

  sha_msg_padder #(.MAX_MESSAGE_LENGTH(1024), .SYMBOL_WIDTH(8)) dut8 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus8)
  );

  sha_msg_padder #(.MAX_MESSAGE_LENGTH(1024), .SYMBOL_WIDTH(32)) dut32 (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus32)
  );

  // Synchronous SRAM models: data appears the cycle after the enable.
  always @(posedge clock) if (bus8.msg_mem_en)  bus8.msg_mem_data  <= msgBytes[bus8.msg_mem_addr];
  always @(posedge clock) if (bus32.msg_mem_en) bus32.msg_mem_data <= mem32[bus32.msg_mem_addr];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed no end of test, expected finish before 500000");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic checkOutput(input string tag, input logic [511:0] observed, input logic [511:0] expected);
    numChecks++;
    assert (observed === expected) else begin
      numFails++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [511:0] withData(input int n);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[511-8*i -: 8] = msgBytes[i];
    return r;
  endfunction

  task automatic applyStimulus(input bit use32, input int len);
    if (use32) begin
      bus32.go_sig  = 1'b1;
      bus32.msg_len = 11'(len);
    end else begin
      bus8.go_sig  = 1'b1;
      bus8.msg_len = 11'(len);
    end
    @(negedge clock);
    bus8.go_sig  = 1'b0;
    bus32.go_sig = 1'b0;
  endtask

  task automatic waitValid(input bit use32, input int budget, output int cyc, output int reads);
    logic v, en;
    cyc   = 1;
    reads = 0;
    forever begin
      v  = use32 ? bus32.blk_valid  : bus8.blk_valid;
      en = use32 ? bus32.msg_mem_en : bus8.msg_mem_en;
      if (en === 1'b1) reads++;
      if (v === 1'b1 || cyc >= budget) break;
      @(negedge clock);
      cyc++;
    end
  endtask

  task automatic acceptBlock(input bit use32);
    if (use32) bus32.blk_ready = 1'b1;
    else       bus8.blk_ready  = 1'b1;
    @(negedge clock);
    bus8.blk_ready  = 1'b0;
    bus32.blk_ready = 1'b0;
  endtask

  task automatic checkResetVals(input bit use32, input string tag);
    if (use32) begin
      checkOutput({tag, "_en"},    bus32.msg_mem_en,   0);
      checkOutput({tag, "_addr"},  bus32.msg_mem_addr, 0);
      checkOutput({tag, "_data"},  bus32.blk_data,     0);
      checkOutput({tag, "_valid"}, bus32.blk_valid,    0);
      checkOutput({tag, "_last"},  bus32.blk_last,     0);
      checkOutput({tag, "_busy"},  bus32.busy,         0);
      checkOutput({tag, "_rdy"},   bus32.pad_msg_rdy,  0);
    end else begin
      checkOutput({tag, "_en"},    bus8.msg_mem_en,   0);
      checkOutput({tag, "_addr"},  bus8.msg_mem_addr, 0);
      checkOutput({tag, "_data"},  bus8.blk_data,     0);
      checkOutput({tag, "_valid"}, bus8.blk_valid,    0);
      checkOutput({tag, "_last"},  bus8.blk_last,     0);
      checkOutput({tag, "_busy"},  bus8.busy,         0);
      checkOutput({tag, "_rdy"},   bus8.pad_msg_rdy,  0);
    end
  endtask

  task automatic singleBlock8(input string tag, input int len, input int expCycle, input int expReads,
                              input logic [511:0] expData, input bit stall);
    int cyc, reads;
    applyStimulus(1'b0, len);
    waitValid(1'b0, expCycle + 10, cyc, reads);
    checkOutput({tag, "_valid"}, bus8.blk_valid, 1);
    checkOutput({tag, "_cycle"}, cyc, expCycle);
    checkOutput({tag, "_reads"}, reads, expReads);
    checkOutput({tag, "_data"},  bus8.blk_data, expData);
    checkOutput({tag, "_last"},  bus8.blk_last, 1);
    checkOutput({tag, "_busy"},  bus8.busy, 1);
    if (stall) begin
      // A go pulse during EMIT must be ignored while the block is held.
      for (int i = 0; i < 10; i++) begin
        bus8.go_sig  = (i == 3);
        bus8.msg_len = 11'd3;
        @(negedge clock);
        checkOutput({tag, "_bp_valid"}, bus8.blk_valid, 1);
        checkOutput({tag, "_bp_data"},  bus8.blk_data, expData);
        checkOutput({tag, "_bp_en"},    bus8.msg_mem_en, 0);
      end
      bus8.go_sig = 1'b0;
    end
    acceptBlock(1'b0);
    checkOutput({tag, "_rdy"},       bus8.pad_msg_rdy, 1);
    checkOutput({tag, "_busy_done"}, bus8.busy, 0);
    checkOutput({tag, "_valid_off"}, bus8.blk_valid, 0);
    @(negedge clock);
    checkOutput({tag, "_rdy_end"}, bus8.pad_msg_rdy, 0);
    checkOutput({tag, "_idle"},    bus8.busy, 0);
  endtask

  initial begin
    int  cyc, reads;
    bit  sawRdy;
    numChecks = 0;
    numFails  = 0;
    reset_n   = 1'b0;
    bus8.go_sig     = 1'b0;
    bus8.msg_len    = '0;
    bus8.blk_ready  = 1'b0;
    bus32.go_sig    = 1'b0;
    bus32.msg_len   = '0;
    bus32.blk_ready = 1'b0;
    for (int i = 0; i < 1024; i++) msgBytes[i] = 8'((i * 7 + 3) & 255);
    msgBytes[0] = 8'h61;
    msgBytes[1] = 8'h62;
    msgBytes[2] = 8'h63;
    for (int i = 0; i < 256; i++) mem32[i] = '0;
    mem32[0] = 32'h11223344;
    mem32[1] = 32'h55AABBCC;

    repeat (2) @(negedge clock);
    checkResetVals(1'b0, "reset8");
    checkResetVals(1'b1, "reset32");
    reset_n = 1'b1;
    @(negedge clock);

    singleBlock8("abc",   3,  6,  3,  {32'h61626380, 416'h0, 64'h18}, 1'b0);
    singleBlock8("len0",  0,  2,  0,  {8'h80, 504'h0}, 1'b0);
    singleBlock8("len55", 55, 58, 55, withData(55) | {440'h0, 8'h80, 64'h1B8}, 1'b1);

    // L=56: pad byte fills the first block, length goes alone into a second one.
    applyStimulus(1'b0, 56);
    waitValid(1'b0, 80, cyc, reads);
    checkOutput("len56_b0_valid", bus8.blk_valid, 1);
    checkOutput("len56_b0_cycle", cyc, 59);
    checkOutput("len56_b0_reads", reads, 56);
    checkOutput("len56_b0_data",  bus8.blk_data, withData(56) | {448'h0, 8'h80, 56'h0});
    checkOutput("len56_b0_last",  bus8.blk_last, 0);
    acceptBlock(1'b0);
    checkOutput("len56_gap_valid", bus8.blk_valid, 0);
    checkOutput("len56_gap_busy",  bus8.busy, 1);
    waitValid(1'b0, 10, cyc, reads);
    checkOutput("len56_b1_valid", bus8.blk_valid, 1);
    checkOutput("len56_b1_cycle", cyc, 2);
    checkOutput("len56_b1_reads", reads, 0);
    checkOutput("len56_b1_data",  bus8.blk_data, {448'h0, 64'h1C0});
    checkOutput("len56_b1_last",  bus8.blk_last, 1);
    acceptBlock(1'b0);
    checkOutput("len56_rdy", bus8.pad_msg_rdy, 1);
    @(negedge clock);

    // L=64 with blk_ready held high: each handshake takes a single cycle.
    bus8.blk_ready = 1'b1;
    applyStimulus(1'b0, 64);
    waitValid(1'b0, 100, cyc, reads);
    checkOutput("len64_b0_valid", bus8.blk_valid, 1);
    checkOutput("len64_b0_cycle", cyc, 67);
    checkOutput("len64_b0_reads", reads, 64);
    checkOutput("len64_b0_data",  bus8.blk_data, withData(64));
    checkOutput("len64_b0_last",  bus8.blk_last, 0);
    @(negedge clock);
    checkOutput("len64_pad_valid", bus8.blk_valid, 0);
    checkOutput("len64_pad_busy",  bus8.busy, 1);
    @(negedge clock);
    checkOutput("len64_b1_valid", bus8.blk_valid, 1);
    checkOutput("len64_b1_data",  bus8.blk_data, {8'h80, 440'h0, 64'h200});
    checkOutput("len64_b1_last",  bus8.blk_last, 1);
    @(negedge clock);
    checkOutput("len64_rdy",  bus8.pad_msg_rdy, 1);
    checkOutput("len64_busy", bus8.busy, 0);
    bus8.blk_ready = 1'b0;
    @(negedge clock);
    checkOutput("len64_rdy_end", bus8.pad_msg_rdy, 0);

    // Abort mid-FETCH: outputs clear at once and no completion pulse follows.
    applyStimulus(1'b0, 20);
    repeat (2) @(negedge clock);
    checkOutput("abort_fetch_en", bus8.msg_mem_en, 1);
    reset_n = 1'b0;
    @(negedge clock);
    checkResetVals(1'b0, "abort");
    reset_n = 1'b1;
    sawRdy  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (bus8.pad_msg_rdy !== 1'b0) sawRdy = 1'b1;
    end
    checkOutput("abort_no_rdy", sawRdy, 0);
    checkOutput("abort_busy",   bus8.busy, 0);
    singleBlock8("abc_again", 3, 6, 3, {32'h61626380, 416'h0, 64'h18}, 1'b0);

    // 32-bit SRAM: second word contributes one byte, the remaining three are dropped.
    applyStimulus(1'b1, 5);
    waitValid(1'b1, 20, cyc, reads);
    checkOutput("w32_valid", bus32.blk_valid, 1);
    checkOutput("w32_cycle", cyc, 5);
    checkOutput("w32_reads", reads, 2);
    checkOutput("w32_data",  bus32.blk_data, {40'h1122334455, 8'h80, 400'h0, 64'h28});
    checkOutput("w32_last",  bus32.blk_last, 1);
    acceptBlock(1'b1);
    checkOutput("w32_rdy", bus32.pad_msg_rdy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
